// File: rtl/module_control_teclado.sv
// module_control_teclado
//   4x4 matrix keypad controller: scans the columns one-hot, debounces a
//   single pressed key, decodes it into a 4-bit code, and holds that code
//   in a one-entry buffer that a consumer drains with a valid/ready handshake.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active low
//   fila[3:0]  in   raw row lines from the keypad (asynchronous, active high)
//   col[3:0]   out  one-hot column drive
//   key_code   out  decoded key, meaningful while key_valid=1
//   key_valid  out  key buffer holds an unread key
//   key_ready  in   consumer takes the key on an edge where key_valid=1
//   overrun    out  sticky: a debounced key was dropped because the buffer was full
module module_control_teclado #(
  parameter int unsigned SCAN_DIV        = 1000,
  parameter int unsigned DEBOUNCE_CYCLES = 10000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] fila,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       overrun
);

  localparam int unsigned DW_W = $clog2(SCAN_DIV + 1);
  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_COMMIT, S_RELEASE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      fila_m_q, fila_s_q;
  logic [1:0]      col_idx_q, col_idx_d;
  logic [DW_W-1:0] dwell_q, dwell_d;
  logic [DB_W-1:0] db_q, db_d;
  logic [3:0]      row_q, row_d;
  logic [3:0]      key_code_q, key_code_d;
  logic            key_valid_q, key_valid_d;
  logic            overrun_q, overrun_d;

  logic            fila_onehot;
  logic [1:0]      row_idx;
  logic            commit;
  logic            handshake;

  function automatic logic [3:0] decode_key(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  // A single pressed key shows up as exactly one row bit; zero or several
  // bits (ghosting / multi-key) are not treated as a press.
  assign fila_onehot = (fila_s_q != 4'd0) && ((fila_s_q & (fila_s_q - 4'd1)) == 4'd0);

  always_comb begin
    case (row_q)
      4'b0001: row_idx = 2'd0;
      4'b0010: row_idx = 2'd1;
      4'b0100: row_idx = 2'd2;
      default: row_idx = 2'd3;
    endcase
  end

  // State register, synchronizer and counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_SCAN;
      fila_m_q    <= 4'd0;
      fila_s_q    <= 4'd0;
      col_idx_q   <= 2'd0;
      dwell_q     <= '0;
      db_q        <= '0;
      row_q       <= 4'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      fila_m_q    <= fila;
      fila_s_q    <= fila_m_q;
      col_idx_q   <= col_idx_d;
      dwell_q     <= dwell_d;
      db_q        <= db_d;
      row_q       <= row_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  // Next-state and counter logic. The column only advances when leaving a
  // column in SCAN or on returning to SCAN; during DEBOUNCE/RELEASE it is frozen.
  always_comb begin
    state_d   = state_q;
    col_idx_d = col_idx_q;
    dwell_d   = dwell_q;
    db_d      = db_q;
    row_d     = row_q;
    case (state_q)
      S_SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (fila_onehot) begin
            row_d   = fila_s_q;
            db_d    = '0;
            state_d = S_DEBOUNCE;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      S_DEBOUNCE: begin
        if (fila_s_q == row_q) begin
          if (db_q == DB_LAST) begin
            db_d    = '0;
            state_d = S_COMMIT;
          end else begin
            db_d = db_q + 1'b1;
          end
        end else begin
          db_d      = '0;
          dwell_d   = '0;
          col_idx_d = col_idx_q + 2'd1;
          state_d   = S_SCAN;
        end
      end
      S_COMMIT: begin
        db_d    = '0;
        state_d = S_RELEASE;
      end
      default: begin
        if (fila_s_q == 4'd0) begin
          if (db_q == DB_LAST) begin
            db_d      = '0;
            dwell_d   = '0;
            col_idx_d = col_idx_q + 2'd1;
            state_d   = S_SCAN;
          end else begin
            db_d = db_q + 1'b1;
          end
        end else begin
          db_d = '0;
        end
      end
    endcase
  end

  // Output logic: column drive and the one-entry key buffer.
  assign commit    = (state_q == S_COMMIT);
  assign handshake = key_valid_q && key_ready;

  always_comb begin
    col         = 4'b0001 << col_idx_q;
    key_code_d  = key_code_q;
    key_valid_d = key_valid_q;
    overrun_d   = overrun_q;
    if (commit && (!key_valid_q || handshake)) begin
      // Buffer empty, or being drained on this very edge: take the new key.
      // A simultaneous drain leaves overrun untouched.
      key_code_d  = decode_key(row_idx, col_idx_q);
      key_valid_d = 1'b1;
    end else if (commit) begin
      overrun_d = 1'b1;
    end else if (handshake) begin
      key_valid_d = 1'b0;
      overrun_d   = 1'b0;
    end
  end

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_module_control_teclado.sv
module tb_module_control_teclado;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] fila;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       overrun;

  // Keypad model: a pressed key connects its row to its column, so the row
  // line only rises while that column is driven. glitch_en overrides it.
  logic       pressed;
  logic [3:0] press_row;
  logic [1:0] press_col;
  logic       glitch_en;
  logic [3:0] glitch_val;

  int n_checks = 0;
  int n_fail   = 0;

  assign fila = glitch_en ? glitch_val :
                ((pressed && col[press_col]) ? press_row : 4'b0000);

  module_control_teclado #(
    .SCAN_DIV       (4),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .fila     (fila),
    .col      (col),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    key_ready = 1'b0;
    pressed   = 1'b0;
    glitch_en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_valid(input int max_cyc, input string tag);
    int n = 0;
    while (!key_valid && n < max_cyc) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, key_valid, 1'b1);
  endtask

  task automatic consume();
    @(negedge clk);
    key_ready = 1'b1;
    @(posedge clk); #1;
    check("consume_valid", key_valid, 1'b0);
    check("consume_overrun", overrun, 1'b0);
    @(negedge clk);
    key_ready = 1'b0;
  endtask

  task automatic press(input logic [3:0] r, input logic [1:0] c);
    @(negedge clk);
    press_row = r;
    press_col = c;
    pressed   = 1'b1;
  endtask

  task automatic release_key();
    @(negedge clk);
    pressed = 1'b0;
    repeat (30) @(posedge clk);
  endtask

  logic [3:0] t_row  [7];
  logic [1:0] t_col  [7];
  logic [3:0] t_code [7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  lat;
    bit  seen;
    t_row[0] = 4'b0010; t_col[0] = 2'd2; t_code[0] = 4'h6;
    t_row[1] = 4'b1000; t_col[1] = 2'd0; t_code[1] = 4'hE;
    t_row[2] = 4'b1000; t_col[2] = 2'd3; t_code[2] = 4'hD;
    t_row[3] = 4'b0100; t_col[3] = 2'd1; t_code[3] = 4'h8;
    t_row[4] = 4'b0001; t_col[4] = 2'd3; t_code[4] = 4'hA;
    t_row[5] = 4'b1000; t_col[5] = 2'd1; t_code[5] = 4'h0;
    t_row[6] = 4'b1000; t_col[6] = 2'd2; t_code[6] = 4'hF;
    press_row  = 4'd0;
    press_col  = 2'd0;
    glitch_val = 4'd0;

    // Reset values and idle scan rotation
    rst = 1'b0; key_ready = 1'b0; pressed = 1'b0; glitch_en = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_col", col, 4'b0001);
    check("rst_code", key_code, 4'h0);
    check("rst_valid", key_valid, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      @(posedge clk); #1;
      check("idle_col", col, 32'(4'b0001 << ((n / 4) % 4)));
    end
    check("idle_valid", key_valid, 1'b0);

    // Key 6 (row1/col2): exact commit latency and no auto-repeat
    do_reset();
    press_row = 4'b0010; press_col = 2'd2; pressed = 1'b1;
    lat = 0;
    while (!key_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("k6_latency", lat, 21);
    check("k6_code", key_code, 4'h6);
    check("k6_col_frozen", col, 4'b0100);
    consume();
    repeat (60) @(posedge clk);
    #1;
    check("k6_no_repeat", key_valid, 1'b0);
    check("k6_no_overrun", overrun, 1'b0);
    release_key();

    // Decode table sweep
    for (int i = 0; i < 7; i++) begin
      do_reset();
      press(t_row[i], t_col[i]);
      wait_valid(200, "dec_valid");
      check("dec_code", key_code, t_code[i]);
      consume();
      release_key();
    end

    // 3-cycle glitch on row0 during col0: no commit, scan moves to col1
    do_reset();
    glitch_val = 4'b0001; glitch_en = 1'b1;
    repeat (3) @(negedge clk);
    glitch_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("glitch_col", col, 4'b0010);
    seen = 1'b0;
    repeat (60) begin
      @(posedge clk); #1;
      if (key_valid) seen = 1'b1;
    end
    check("glitch_no_commit", seen, 1'b0);

    // Multi-hot rows ignored
    do_reset();
    press(4'b0011, 2'd0);
    seen = 1'b0;
    repeat (150) begin
      @(posedge clk); #1;
      if (key_valid) seen = 1'b1;
    end
    check("multihot_no_commit", seen, 1'b0);
    check("multihot_overrun", overrun, 1'b0);
    release_key();

    // Overrun: key 1 kept, key 9 dropped, handshake clears both flags
    do_reset();
    press(4'b0001, 2'd0);
    wait_valid(200, "ovr_k1_valid");
    check("ovr_k1_code", key_code, 4'h1);
    release_key();
    press(4'b0100, 2'd2);
    lat = 0;
    while (!overrun && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    check("ovr_set", overrun, 1'b1);
    check("ovr_code_kept", key_code, 4'h1);
    check("ovr_valid_kept", key_valid, 1'b1);
    release_key();
    consume();

    // Reset mid-debounce: outputs drop immediately, key abandoned
    lat = 0;
    while (col == 4'b0100 && lat < 50) begin @(posedge clk); #1; lat++; end
    while (col != 4'b0100 && lat < 50) begin @(posedge clk); #1; lat++; end
    check("rdb_found_col2", col, 4'b0100);
    press_row = 4'b0010; press_col = 2'd2; pressed = 1'b1;
    repeat (8) @(posedge clk);
    #2;
    check("rdb_pre_col", col, 4'b0100);
    check("rdb_pre_code", key_code, 4'h1);
    rst = 1'b0;
    #1;
    check("rdb_col", col, 4'b0001);
    check("rdb_code", key_code, 4'h0);
    check("rdb_valid", key_valid, 1'b0);
    check("rdb_overrun", overrun, 1'b0);
    pressed = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rdb_restart_col", col, 4'b0001);
    seen = 1'b0;
    repeat (100) begin
      @(posedge clk); #1;
      if (key_valid) seen = 1'b1;
    end
    check("rdb_no_commit", seen, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/module_control_teclado.md
MODULE_CONTROL_TECLADO -- requirements
Module: module_control_teclado

Interface
REQ-001 Parameter SCAN_DIV, default 1000, meaning clock cycles each column stays driven during scan (>=2).
REQ-002 Parameter DEBOUNCE_CYCLES, default 10000, meaning consecutive stable cycles required for press/release acceptance (>=2).
REQ-003 clk  input  1  single system clock, all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 fila  input  4  raw keypad row lines, asynchronous, active-high.
REQ-006 col  output  4  one-hot column drive.
REQ-007 key_code  output  4  decoded key value, valid while key_valid=1.
REQ-008 key_valid  output  1  one-entry key buffer full.
REQ-009 key_ready  input  1  consumer accepts key when key_valid=1 on same edge.
REQ-010 overrun  output  1  sticky flag: a debounced key was dropped because the buffer was full.

Function
REQ-011 fila SHALL pass through a 2-flop synchronizer; "fila_s" below is the synchronized value (2-cycle input latency).
REQ-012 FSM states SHALL be SCAN, DEBOUNCE, COMMIT, RELEASE.
REQ-013 SCAN: col rotates 0001->0010->0100->1000->0001, each value held exactly SCAN_DIV cycles; fila_s sampled on the last dwell cycle.
REQ-014 SCAN: sample one-hot -> capture row index r and column index c, freeze col, go DEBOUNCE; sample 0 or multi-hot -> advance column, stay SCAN.
REQ-015 DEBOUNCE: counter increments each cycle fila_s equals captured row; on reaching DEBOUNCE_CYCLES go COMMIT; any mismatch -> clear counter, advance column, return to SCAN.
REQ-016 COMMIT (one cycle): buffer empty -> load key_code, key_valid=1 on next edge; buffer full -> drop key, set overrun; always go RELEASE.
REQ-017 RELEASE: col stays frozen; counter increments each cycle fila_s==0, clears on any nonzero; on reaching DEBOUNCE_CYCLES advance column, go SCAN.
REQ-018 Decode (row r, col c): r0: 1,2,3,A; r1: 4,5,6,B; r2: 7,8,9,C; r3: E(*),0,F(#),D for c=0..3.
REQ-019 Buffer handshake: key_valid && key_ready at an edge clears key_valid; key_code holds last value.
REQ-020 Simultaneous handshake and COMMIT on same edge: old key consumed, new key loaded, key_valid stays 1, overrun unchanged.
REQ-021 overrun SHALL clear on a completed handshake unless REQ-016 sets it on the same edge (set wins).
REQ-022 Held key SHALL produce exactly one COMMIT; no auto-repeat.
REQ-023 Dwell and debounce counters SHALL saturate/restart without wrapping past their limits; sized ceil(log2(param+1)).

Reset
REQ-024 rst=0 SHALL immediately force: state SCAN, col=0001, key_code=0, key_valid=0, overrun=0, all counters and synchronizer flops 0.
REQ-025 Reset asserted mid-DEBOUNCE/RELEASE SHALL abandon the key with no commit; scan restarts at column 0 one cycle after rst deasserts.

Verification (SCAN_DIV=4, DEBOUNCE_CYCLES=8)
REQ-026 Idle fila=0000 after reset -> col cycles 0001,0010,0100,1000 every 4 cycles; key_valid stays 0.
REQ-027 fila=0010 held only while col=0100, key_ready=0 -> key_code=4'h6, key_valid=1 after debounce, exactly once while held.
REQ-028 fila=0001 glitch for 3 cycles during col=0001 -> no commit, scan resumes at col=0010.
REQ-029 Press 1 (row0/col0), release, press 9 (row2/col2) with key_ready=0 -> key_code=4'h1 retained, overrun=1; then key_ready=1 one cycle -> key_valid=0, overrun=0.
REQ-030 fila=1000 during col=0001 -> key_code=4'hE; fila=0011 (multi-hot) -> ignored, no commit.
REQ-031 rst pulsed low during DEBOUNCE -> all outputs at reset values immediately, no key_valid afterwards.
